oam_dma_ctrl: RTL and testbench
===============================

Name: oam_dma_ctrl

Overview:
OAM DMA sequencer and bus arbiter between the CPU control unit and the shared system bus. A CPU write to register FF46 starts a 160-byte copy from {src,00}..{src,9F} into OAM at FE00-FE9F. While the copy runs, the block owns the external address/data bus and locks the CPU out of everything except HRAM and FF46.

Parameters:
XFER_LEN, 160, bytes per DMA transfer; index counter width fixed at 8 bits.
DMA_REG_ADDR, 16'hFF46, CPU address of the DMA source register.

Ports:
clk_i  input  1  system clock
rst_i  input  1  asynchronous reset, active-high
tick_i  input  1  one-clock pulse per M-cycle; all DMA progress advances only on tick_i
cpu_addr_i  input  16  CPU address
cpu_data_i  input  8  CPU write data
cpu_wr_i  input  1  CPU write strobe, qualified by tick_i
cpu_rd_i  input  1  CPU read request
cpu_data_o  output  8  read data returned to CPU
bus_addr_o  output  16  system bus address
bus_data_o  output  8  system bus write data
bus_rd_o  output  1  system bus read enable
bus_wr_o  output  1  system bus write enable
bus_data_i  input  8  system bus read data, valid in the same cycle as bus_addr_o
oam_addr_o  output  8  OAM byte index
oam_data_o  output  8  OAM write data
oam_wr_o  output  1  OAM write pulse, one clock wide
dma_active_o  output  1  high while the block owns the bus

Behaviour:
- Reset (async, active-high): state IDLE; src_reg=8'hFF; idx=0; oam_wr_o=0; oam_addr_o=0; oam_data_o=0; dma_active_o=0; bus outputs follow the CPU passthrough rule.
- FF46 write:
  - Any cycle with tick_i & cpu_wr_i & cpu_addr_i==DMA_REG_ADDR latches src_reg=cpu_data_i.
  - The state goes to START. This applies from any state, so a write during START or XFER restarts the transfer.
- FF46 read: cpu_data_o=src_reg in all states.
- Effective source:
  - eff_src = src_reg.
  - If src_reg >= 8'hE0, eff_src = src_reg - 8'h20, mapping echo RAM onto WRAM.
- States:
  - IDLE: passthrough. bus_addr_o=cpu_addr_i, bus_data_o=cpu_data_i, bus_rd_o=cpu_rd_i, bus_wr_o=cpu_wr_i. cpu_data_o=bus_data_i, except on FF46.
  - START: one M-cycle delay. Set idx=0 and dma_active_o=1. On the next tick_i, go to XFER. Bus is still passthrough in START.
  - XFER: bus_addr_o={eff_src,idx}, bus_rd_o=1, bus_wr_o=0.
    - On each tick_i edge: oam_data_o<=bus_data_i, oam_addr_o<=idx, oam_wr_o<=1 for exactly one clock, idx<=idx+1.
    - When the captured idx==XFER_LEN-1, go to IDLE. dma_active_o falls on the same edge that raises the final oam_wr_o.
- CPU lockout: while dma_active_o=1 (START or XFER), a CPU access to FF80-FFFE or FF46 passes as in IDLE, except that in XFER the bus stays owned by DMA.
  - HRAM read data returns via bus_data_i only in START.
  - In XFER, HRAM is served by a separate path and outside the scope of this block: cpu_data_o=8'hFF.
  - All other CPU reads return 8'hFF. All other CPU writes are dropped, with bus_wr_o=0.
- Latency: FF46 write at tick N → first OAM write on tick N+2 → last OAM write on tick N+161. Total of 161 M-cycles with dma_active_o=1.
- Boundaries:
  - idx never exceeds 159.
  - tick_i=0 freezes all state.
  - A restart mid-XFER discards progress; OAM bytes already written stay written.
  - Reset mid-XFER aborts immediately with no further oam_wr_o.

Test Plan:
- Reset → src_reg=FF, dma_active_o=0, oam_wr_o=0; CPU read FF46 → 8'hFF.
- Write FF46=C1, memory C100+i=i^5A → 160 oam_wr_o pulses, OAM[i]=i^5A, addresses C100..C19F. dma_active_o high for exactly 161 ticks.
- Write FF46=E2 → bus_addr_o sweeps C200..C29F.
- During XFER: CPU write 0xAA to C000 → bus_wr_o stays 0. CPU read of 8000 → 8'hFF. CPU read FF46 → current src.
- At idx=50, write FF46=D0 → idx restarts at 0 after one START M-cycle, source D000, 160 further writes.
- Assert rst_i at idx=80 → dma_active_o=0 and oam_wr_o=0 immediately; no further OAM writes.

Source files
------------

// File: rtl/oam_dma_ctrl.sv
// OAM DMA sequencer and system-bus arbiter between CPU and shared bus.
// Ports: clk_i/rst_i/tick_i, cpu_* side, bus_* side, oam_* side, dma_active_o.
module oam_dma_ctrl #(
  parameter int          XFER_LEN     = 160,
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        tick_i,
  input  logic [15:0] cpu_addr_i,
  input  logic [7:0]  cpu_data_i,
  input  logic        cpu_wr_i,
  input  logic        cpu_rd_i,
  output logic [7:0]  cpu_data_o,
  output logic [15:0] bus_addr_o,
  output logic [7:0]  bus_data_o,
  output logic        bus_rd_o,
  output logic        bus_wr_o,
  input  logic [7:0]  bus_data_i,
  output logic [7:0]  oam_addr_o,
  output logic [7:0]  oam_data_o,
  output logic        oam_wr_o,
  output logic        dma_active_o
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    XFER
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  state_t      state;
  state_t      stateNext;
  logic [7:0]  srcReg;
  logic [7:0]  idx;
  logic [7:0]  effSrc;
  logic        isReg;
  logic        isHram;
  logic        regWr;
  logic        lastByte;

  assign isReg    = (cpu_addr_i == DMA_REG_ADDR);
  assign isHram   = (cpu_addr_i >= 16'hFF80) &&
                    (cpu_addr_i <= 16'hFFFE);
  assign regWr    = tick_i & cpu_wr_i & isReg;
  assign lastByte = (idx == LAST_IDX);

  // Echo RAM (E0xx and up) folds back onto WRAM.
  assign effSrc = (srcReg >= 8'hE0) ? (srcReg - 8'h20) : srcReg;

  assign dma_active_o = (state != IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      srcReg     <= 8'hFF;
      idx        <= 8'h00;
      oam_wr_o   <= 1'b0;
      oam_addr_o <= 8'h00;
      oam_data_o <= 8'h00;
    end else begin
      state    <= stateNext;
      oam_wr_o <= 1'b0;
      // A register write wins over a pending byte: restart drops it.
      if (regWr) begin
        srcReg <= cpu_data_i;
        idx    <= 8'h00;
      end else if (tick_i && state == XFER) begin
        oam_data_o <= bus_data_i;
        oam_addr_o <= idx;
        oam_wr_o   <= 1'b1;
        idx        <= lastByte ? 8'h00 : idx + 8'h01;
      end
    end
  end

  always_comb begin
    stateNext = state;
    if (regWr) begin
      stateNext = START;
    end else if (tick_i) begin
      unique case (1'b1)
        (state == START):          stateNext = XFER;
        (state == XFER) && lastByte: stateNext = IDLE;
        default: ;
      endcase
    end
  end

  always_comb begin
    bus_addr_o = cpu_addr_i;
    bus_data_o = cpu_data_i;
    bus_rd_o   = cpu_rd_i;
    bus_wr_o   = cpu_wr_i;
    cpu_data_o = bus_data_i;
    unique case (1'b1)
      (state == START): begin
        if (!(isReg || isHram)) begin
          bus_rd_o   = 1'b0;
          bus_wr_o   = 1'b0;
          cpu_data_o = 8'hFF;
        end
      end
      (state == XFER): begin
        bus_addr_o = {effSrc, idx};
        bus_data_o = 8'h00;
        bus_rd_o   = 1'b1;
        bus_wr_o   = 1'b0;
        cpu_data_o = 8'hFF;
      end
      default: ;
    endcase
    if (isReg) cpu_data_o = srcReg;
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Bench for oam_dma_ctrl: vector table for bus muxing,
// directed sequences for transfer, restart and reset abort.
module tb_oam_dma_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic [15:0] cpuAddr;
  logic [7:0]  cpuData;
  logic        cpuWr;
  logic        cpuRd;
  logic [7:0]  cpuDataOut;
  logic [15:0] busAddr;
  logic [7:0]  busDataOut;
  logic        busRd;
  logic        busWr;
  logic [7:0]  busDataIn;
  logic [7:0]  oamAddr;
  logic [7:0]  oamData;
  logic        oamWr;
  logic        dmaActive;

  logic        useMem;
  logic [7:0]  bdDrv;

  int errors = 0;
  int checks = 0;
  int wrCount = 0;
  int widthErr = 0;
  logic prevWr = 1'b0;
  logic [7:0]  oamMem [0:255];
  logic [7:0]  addrLog [0:1023];
  logic [15:0] busSeen [0:511];

  typedef struct packed {
    logic [1:0]  phase;
    logic [15:0] a;
    logic [7:0]  d;
    logic        wr;
    logic        rd;
    logic [7:0]  bd;
    logic [7:0]  eCpu;
    logic [15:0] eAddr;
    logic [7:0]  eData;
    logic        eRd;
    logic        eWr;
  } vec_t;

  vec_t vecs [0:15];

  always #5 clk = ~clk;

  function automatic logic [7:0] memFn(input logic [15:0] a);
    return a[7:0] ^ 8'h5A ^ a[15:8] ^ 8'hC1;
  endfunction

  assign busDataIn = useMem ? memFn(busAddr) : bdDrv;

  oam_dma_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .tick_i      (tick),
    .cpu_addr_i  (cpuAddr),
    .cpu_data_i  (cpuData),
    .cpu_wr_i    (cpuWr),
    .cpu_rd_i    (cpuRd),
    .cpu_data_o  (cpuDataOut),
    .bus_addr_o  (busAddr),
    .bus_data_o  (busDataOut),
    .bus_rd_o    (busRd),
    .bus_wr_o    (busWr),
    .bus_data_i  (busDataIn),
    .oam_addr_o  (oamAddr),
    .oam_data_o  (oamData),
    .oam_wr_o    (oamWr),
    .dma_active_o(dmaActive)
  );

  always @(negedge clk) begin
    if (oamWr) begin
      if (prevWr) widthErr++;
      oamMem[oamAddr] = oamData;
      if (wrCount < 1024) addrLog[wrCount] = oamAddr;
      wrCount++;
    end
    prevWr = oamWr;
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mc();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    #1;
  endtask

  task automatic cpuWrTick(input logic [15:0] a,
                           input logic [7:0] d);
    @(negedge clk);
    cpuAddr = a;
    cpuData = d;
    cpuWr   = 1'b1;
    tick    = 1'b1;
    @(negedge clk);
    tick    = 1'b0;
    cpuWr   = 1'b0;
    cpuAddr = 16'h0000;
    cpuData = 8'h00;
    #1;
  endtask

  task automatic applyPhase(input logic [1:0] p);
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].phase == p) begin
        cpuAddr = vecs[i].a;
        cpuData = vecs[i].d;
        cpuWr   = vecs[i].wr;
        cpuRd   = vecs[i].rd;
        bdDrv   = vecs[i].bd;
        useMem  = 1'b0;
        #1;
        checks++;
        if (cpuDataOut !== vecs[i].eCpu ||
            busAddr !== vecs[i].eAddr ||
            busDataOut !== vecs[i].eData ||
            busRd !== vecs[i].eRd ||
            busWr !== vecs[i].eWr) begin
          errors++;
          $display("FAIL vec%0d: cpu=%h addr=%h data=%h rd=%b wr=%b expected cpu=%h addr=%h data=%h rd=%b wr=%b",
                   i, cpuDataOut, busAddr, busDataOut, busRd, busWr,
                   vecs[i].eCpu, vecs[i].eAddr, vecs[i].eData,
                   vecs[i].eRd, vecs[i].eWr);
        end
      end
    end
    cpuAddr = 16'h0000;
    cpuData = 8'h00;
    cpuWr   = 1'b0;
    cpuRd   = 1'b0;
    useMem  = 1'b1;
    #1;
  endtask

  task automatic runDma(input int pauseAt, output int n);
    n = 0;
    while (dmaActive && n < 400) begin
      if (n == pauseAt) applyPhase(2'd2);
      busSeen[n] = busAddr;
      mc();
      n++;
    end
  endtask

  task automatic chkOam(input string name, input logic [7:0] page);
    int bad = 0;
    for (int i = 0; i < 160; i++)
      if (oamMem[i] !== memFn({page, 8'(i)})) bad++;
    chk(name, bad, 0);
  endtask

  task automatic chkSweep(input string name, input int off,
                          input logic [15:0] base);
    int bad = 0;
    for (int k = 0; k < 160; k++)
      if (busSeen[k + off] !== base + 16'(k)) bad++;
    chk(name, bad, 0);
  endtask

  task automatic clrOam();
    for (int i = 0; i < 256; i++) oamMem[i] = 8'hXX;
  endtask

  task automatic rdReg(input string name, input logic [7:0] exp);
    cpuAddr = 16'hFF46;
    cpuRd   = 1'b1;
    #1;
    chk(name, cpuDataOut, exp);
    cpuAddr = 16'h0000;
    cpuRd   = 1'b0;
    #1;
  endtask

  initial begin
    int n;
    int base;
    int guard;

    vecs[0]  = '{2'd0, 16'h1234, 8'h56, 1'b0, 1'b1, 8'h9C, 8'h9C, 16'h1234, 8'h56, 1'b1, 1'b0};
    vecs[1]  = '{2'd0, 16'hC000, 8'hAA, 1'b1, 1'b0, 8'h11, 8'h11, 16'hC000, 8'hAA, 1'b0, 1'b1};
    vecs[2]  = '{2'd0, 16'hFF46, 8'h00, 1'b0, 1'b1, 8'h33, 8'hFF, 16'hFF46, 8'h00, 1'b1, 1'b0};
    vecs[3]  = '{2'd0, 16'hFF46, 8'h77, 1'b1, 1'b0, 8'h33, 8'hFF, 16'hFF46, 8'h77, 1'b0, 1'b1};
    vecs[4]  = '{2'd0, 16'hFF90, 8'h00, 1'b0, 1'b1, 8'h42, 8'h42, 16'hFF90, 8'h00, 1'b1, 1'b0};
    vecs[5]  = '{2'd1, 16'hFF90, 8'h00, 1'b0, 1'b1, 8'h44, 8'h44, 16'hFF90, 8'h00, 1'b1, 1'b0};
    vecs[6]  = '{2'd1, 16'h8000, 8'h00, 1'b0, 1'b1, 8'h12, 8'hFF, 16'h8000, 8'h00, 1'b0, 1'b0};
    vecs[7]  = '{2'd1, 16'hC000, 8'hAA, 1'b1, 1'b0, 8'h12, 8'hFF, 16'hC000, 8'hAA, 1'b0, 1'b0};
    vecs[8]  = '{2'd1, 16'hFF46, 8'h00, 1'b0, 1'b1, 8'h12, 8'hC1, 16'hFF46, 8'h00, 1'b1, 1'b0};
    vecs[9]  = '{2'd1, 16'hFFFE, 8'h05, 1'b1, 1'b0, 8'h66, 8'h66, 16'hFFFE, 8'h05, 1'b0, 1'b1};
    vecs[10] = '{2'd1, 16'hFFFF, 8'h01, 1'b1, 1'b0, 8'h66, 8'hFF, 16'hFFFF, 8'h01, 1'b0, 1'b0};
    vecs[11] = '{2'd2, 16'hC000, 8'hAA, 1'b1, 1'b0, 8'h12, 8'hFF, 16'hC103, 8'h00, 1'b1, 1'b0};
    vecs[12] = '{2'd2, 16'h8000, 8'h00, 1'b0, 1'b1, 8'h12, 8'hFF, 16'hC103, 8'h00, 1'b1, 1'b0};
    vecs[13] = '{2'd2, 16'hFF46, 8'h00, 1'b0, 1'b1, 8'h12, 8'hC1, 16'hC103, 8'h00, 1'b1, 1'b0};
    vecs[14] = '{2'd2, 16'hFF90, 8'h00, 1'b0, 1'b1, 8'h44, 8'hFF, 16'hC103, 8'h00, 1'b1, 1'b0};
    vecs[15] = '{2'd2, 16'hFF46, 8'h99, 1'b1, 1'b0, 8'h12, 8'hC1, 16'hC103, 8'h00, 1'b1, 1'b0};

    rst     = 1'b1;
    tick    = 1'b0;
    cpuAddr = 16'h0000;
    cpuData = 8'h00;
    cpuWr   = 1'b0;
    cpuRd   = 1'b0;
    useMem  = 1'b1;
    bdDrv   = 8'h00;
    clrOam();

    repeat (3) @(negedge clk);
    #1;
    chk("rst_active", dmaActive, 0);
    chk("rst_oam_wr", oamWr, 0);
    chk("rst_oam_addr", oamAddr, 0);
    chk("rst_oam_data", oamData, 0);
    @(negedge clk) rst = 1'b0;
    #1;
    rdReg("rst_ff46", 8'hFF);

    applyPhase(2'd0);

    // C1 transfer, with START and mid-XFER lockout vectors
    base = wrCount;
    cpuWrTick(16'hFF46, 8'hC1);
    chk("c1_active_start", dmaActive, 1);
    applyPhase(2'd1);
    runDma(4, n);
    chk("c1_active_ticks", n, 161);
    chk("c1_writes", wrCount - base, 160);
    chkOam("c1_oam", 8'hC1);
    chkSweep("c1_sweep", 1, 16'hC100);
    chk("c1_first_idx", addrLog[base], 0);
    chk("c1_last_idx", addrLog[base + 159], 159);

    // echo source E2 folds to C2
    clrOam();
    base = wrCount;
    cpuWrTick(16'hFF46, 8'hE2);
    runDma(-1, n);
    chk("e2_active_ticks", n, 161);
    chk("e2_writes", wrCount - base, 160);
    chkSweep("e2_sweep", 1, 16'hC200);
    chkOam("e2_oam", 8'hC2);
    rdReg("e2_ff46", 8'hE2);

    // restart at idx 50 with D0
    clrOam();
    base = wrCount;
    cpuWrTick(16'hFF46, 8'hC1);
    guard = 0;
    while (wrCount - base < 50 && guard < 200) begin
      mc();
      guard++;
    end
    chk("rs_reach50", wrCount - base, 50);
    cpuWrTick(16'hFF46, 8'hD0);
    base = wrCount;
    chk("rs_active", dmaActive, 1);
    mc();
    chk("rs_start_gap", wrCount - base, 0);
    runDma(-1, n);
    chk("rs_xfer_ticks", n, 160);
    chk("rs_writes", wrCount - base, 160);
    chk("rs_first_idx", addrLog[base], 0);
    chkSweep("rs_sweep", 0, 16'hD000);
    chkOam("rs_oam", 8'hD0);
    rdReg("rs_ff46", 8'hD0);

    // reset abort at idx 80
    base = wrCount;
    cpuWrTick(16'hFF46, 8'hC1);
    guard = 0;
    while (wrCount - base < 80 && guard < 200) begin
      mc();
      guard++;
    end
    chk("ra_reach80", wrCount - base, 80);
    rst = 1'b1;
    #1;
    chk("ra_active", dmaActive, 0);
    chk("ra_oam_wr", oamWr, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    base = wrCount;
    repeat (20) mc();
    chk("ra_no_writes", wrCount - base, 0);
    chk("ra_idle", dmaActive, 0);
    rdReg("ra_ff46", 8'hFF);

    chk("oam_wr_width", widthErr, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
